// File: rtl/dial_pkg.sv
// rtl/dial_pkg.sv - shared types and constants for the dial front end
package dial_pkg;

    localparam int DIAL_POSITIONS = 20;
    localparam int COUNT_W        = 5;

    typedef enum logic [2:0] {
        IDLE,
        CW1,
        CW2,
        CW3,
        CCW1,
        CCW2,
        CCW3
    } dial_state_t;

endpackage

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - 2-FF synchronizer followed by a stable-count debounce filter
module debounce_filter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // filtered value; the flip happens on the DEBOUNCE_CYCLES-th such edge.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/rotary_dial_tracker.sv
// rtl/rotary_dial_tracker.sv - quadrature detent decoder and modulo dial position
module rotary_dial_tracker
    import dial_pkg::*;
#(
    parameter int POSITIONS       = DIAL_POSITIONS,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               RotA,
    input  logic               RotB,
    input  logic               RotCenter,
    output logic [COUNT_W-1:0] Count,
    output logic               Right,
    output logic               Left,
    output logic               Center,
    output logic               Step
);

    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(POSITIONS - 1);

    logic        a_filt, b_filt;
    logic [1:0]  ab;
    dial_state_t state_q, state_d;
    logic        step_cw, step_ccw;

    logic [COUNT_W-1:0] count_q, count_d;
    logic               right_q, right_d;
    logic               left_q, left_d;
    logic               step_q, step_d;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .Clk(Clk), .Rst(Rst), .din(RotA), .dout(a_filt)
    );
    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .Clk(Clk), .Rst(Rst), .din(RotB), .dout(b_filt)
    );
    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
        .Clk(Clk), .Rst(Rst), .din(RotCenter), .dout(Center)
    );

    assign ab = {a_filt, b_filt};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Codes not listed for a state (including two-bit jumps) hold the state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ab == 2'b10) state_d = CW1;  else if (ab == 2'b01) state_d = CCW1;
            CW1:  if (ab == 2'b11) state_d = CW2;  else if (ab == 2'b00) state_d = IDLE;
            CW2:  if (ab == 2'b01) state_d = CW3;  else if (ab == 2'b10) state_d = CW1;
            CW3:  if (ab == 2'b00) state_d = IDLE; else if (ab == 2'b11) state_d = CW2;
            CCW1: if (ab == 2'b11) state_d = CCW2; else if (ab == 2'b00) state_d = IDLE;
            CCW2: if (ab == 2'b10) state_d = CCW3; else if (ab == 2'b01) state_d = CCW1;
            CCW3: if (ab == 2'b00) state_d = IDLE; else if (ab == 2'b11) state_d = CCW2;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        step_cw  = (state_q == CW3)  && (ab == 2'b00);
        step_ccw = (state_q == CCW3) && (ab == 2'b00);
    end

    always_comb begin
        count_d = count_q;
        right_d = right_q;
        left_d  = left_q;
        step_d  = 1'b0;
        if (step_cw) begin
            count_d = (count_q == COUNT_LAST) ? '0 : count_q + COUNT_W'(1);
            right_d = 1'b1;
            left_d  = 1'b0;
            step_d  = 1'b1;
        end else if (step_ccw) begin
            count_d = (count_q == '0) ? COUNT_LAST : count_q - COUNT_W'(1);
            right_d = 1'b0;
            left_d  = 1'b1;
            step_d  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q <= '0;
            right_q <= 1'b0;
            left_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            right_q <= right_d;
            left_q  <= left_d;
            step_q  <= step_d;
        end
    end

    assign Count = count_q;
    assign Right = right_q;
    assign Left  = left_q;
    assign Step  = step_q;

endmodule

// File: tb/tb_rotary_dial_tracker.sv
// tb/tb_rotary_dial_tracker.sv - self-checking bench for rotary_dial_tracker
module tb_rotary_dial_tracker;

    localparam int POS = 20;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       RotA, RotB, RotCenter;
    logic [4:0] Count;
    logic       Right, Left, Center, Step;

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;
    int both_err = 0;

    rotary_dial_tracker #(.POSITIONS(POS), .DEBOUNCE_CYCLES(4)) dut (
        .Clk(Clk), .Rst(Rst), .RotA(RotA), .RotB(RotB), .RotCenter(RotCenter),
        .Count(Count), .Right(Right), .Left(Left), .Center(Center), .Step(Step)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Step) step_cnt++;
        if (Right && Left) both_err++;
    end

    typedef struct {
        logic [1:0] ab;
        int         exp_count;
        logic       exp_r;
        logic       exp_l;
        int         exp_steps;
    } vec_t;

    vec_t tbl[$];

    int         m_d, m_count, m_steps;
    logic       m_r, m_l;

    task automatic step_clk(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [1:0] c, input int n);
        RotA = c[1];
        RotB = c[0];
        step_clk(n);
    endtask

    task automatic add(input logic [1:0] ab, input int c, input logic r, input logic l, input int s);
        vec_t v;
        v.ab = ab; v.exp_count = c; v.exp_r = r; v.exp_l = l; v.exp_steps = s;
        tbl.push_back(v);
    endtask

    function automatic int phase_of(input logic [1:0] c);
        case (c)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Model: signed displacement in quarter-steps from the last rest position.
    task automatic model_apply(input logic [1:0] c);
        int cur;
        int delta;
        cur   = ((m_d % 4) + 4) % 4;
        delta = (phase_of(c) - cur + 4) % 4;
        if (delta == 1) begin
            if (m_d == 3) begin
                m_d = 0; m_count = (m_count + 1) % POS; m_r = 1'b1; m_l = 1'b0; m_steps++;
            end else begin
                m_d++;
            end
        end else if (delta == 3) begin
            if (m_d == -3) begin
                m_d = 0; m_count = (m_count + POS - 1) % POS; m_r = 1'b0; m_l = 1'b1; m_steps++;
            end else begin
                m_d--;
            end
        end
    endtask

    initial begin
        int base;
        int s0;
        int cmax;
        logic [1:0] cw_seq[4];
        logic [1:0] ccw_seq[4];
        cw_seq  = '{2'b10, 2'b11, 2'b01, 2'b00};
        ccw_seq = '{2'b01, 2'b11, 2'b10, 2'b00};

        // Reset with pins toggling
        Rst = 1'b1; RotA = 1'b0; RotB = 1'b0; RotCenter = 1'b0;
        for (int i = 0; i < 3; i++) begin
            RotA = 1'($urandom_range(0, 1));
            RotB = 1'($urandom_range(0, 1));
            RotCenter = 1'($urandom_range(0, 1));
            step_clk(1);
        end
        chk("rst_count", Count, 0);
        chk("rst_right", Right, 0);
        chk("rst_left", Left, 0);
        chk("rst_center", Center, 0);
        chk("rst_step", Step, 0);
        RotA = 1'b0; RotB = 1'b0; RotCenter = 1'b0;
        step_clk(1);
        Rst = 1'b0;
        step_clk(12);
        chk("rst_release_steps", step_cnt, 0);
        chk("rst_release_count", Count, 0);

        // Directed table: CW x3, CCW x4 (wrap), CW (wrap), back-out, illegal, CCW back-out
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 3; k++) add(cw_seq[k], d, d > 0, 1'b0, d);
            add(2'b00, d + 1, 1'b1, 1'b0, d + 1);
        end
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 3; k++) add(ccw_seq[k], (23 - d) % 20, d == 0, d > 0, 3 + d);
            add(2'b00, (22 - d) % 20, 1'b0, 1'b1, 4 + d);
        end
        for (int k = 0; k < 3; k++) add(cw_seq[k], 19, 1'b0, 1'b1, 7);
        add(2'b00, 0, 1'b1, 1'b0, 8);
        add(2'b10, 0, 1'b1, 1'b0, 8);
        add(2'b11, 0, 1'b1, 1'b0, 8);
        add(2'b10, 0, 1'b1, 1'b0, 8);
        add(2'b00, 0, 1'b1, 1'b0, 8);
        add(2'b11, 0, 1'b1, 1'b0, 8);
        add(2'b00, 0, 1'b1, 1'b0, 8);
        add(2'b01, 0, 1'b1, 1'b0, 8);
        add(2'b11, 0, 1'b1, 1'b0, 8);
        add(2'b01, 0, 1'b1, 1'b0, 8);
        add(2'b00, 0, 1'b1, 1'b0, 8);

        base = step_cnt;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].ab, 10);
            chk($sformatf("vec%0d_count", i), Count, tbl[i].exp_count);
            chk($sformatf("vec%0d_right", i), Right, tbl[i].exp_r);
            chk($sformatf("vec%0d_left", i), Left, tbl[i].exp_l);
            chk($sformatf("vec%0d_steps", i), step_cnt - base, tbl[i].exp_steps);
        end

        // Latency: Count changes on edge 7 after the final 00
        for (int k = 0; k < 3; k++) apply(cw_seq[k], 10);
        apply(2'b00, 6);
        chk("lat_edge6_count", Count, 0);
        chk("lat_edge6_step", Step, 0);
        step_clk(1);
        chk("lat_edge7_count", Count, 1);
        chk("lat_edge7_step", Step, 1);
        step_clk(1);
        chk("lat_edge8_step", Step, 0);
        step_clk(8);

        // Short glitch on RotA
        s0 = step_cnt;
        RotA = 1'b1;
        step_clk(2);
        RotA = 1'b0;
        step_clk(10);
        chk("glitch_count", Count, 1);
        chk("glitch_steps", step_cnt - s0, 0);
        for (int k = 0; k < 4; k++) apply(cw_seq[k], 10);
        chk("after_glitch_count", Count, 2);

        // Reset in the middle of a detent
        apply(2'b10, 10);
        apply(2'b11, 10);
        Rst = 1'b1;
        step_clk(2);
        chk("midrst_count", Count, 0);
        chk("midrst_right", Right, 0);
        Rst = 1'b0;
        s0 = step_cnt;
        apply(2'b01, 10);
        apply(2'b00, 10);
        chk("midrst_after_count", Count, 0);
        chk("midrst_after_steps", step_cnt - s0, 0);

        // Center: short pulse filtered out, long one lands on edge 6
        RotCenter = 1'b1;
        step_clk(3);
        RotCenter = 1'b0;
        cmax = 0;
        for (int i = 0; i < 10; i++) begin
            step_clk(1);
            if (Center) cmax = 1;
        end
        chk("center_short", cmax, 0);
        RotCenter = 1'b1;
        step_clk(5);
        chk("center_edge5", Center, 0);
        step_clk(1);
        chk("center_edge6", Center, 1);
        for (int k = 0; k < 4; k++) apply(cw_seq[k], 10);
        chk("center_rot_count", Count, 1);
        chk("center_rot_center", Center, 1);
        RotCenter = 1'b0;
        step_clk(8);
        chk("center_release", Center, 0);

        // Randomized codes against the displacement model
        Rst = 1'b1; RotA = 1'b0; RotB = 1'b0; RotCenter = 1'b0;
        step_clk(2);
        Rst = 1'b0;
        step_clk(2);
        m_d = 0; m_count = 0; m_steps = 0; m_r = 1'b0; m_l = 1'b0;
        base = step_cnt;
        for (int i = 0; i < 60; i++) begin
            logic [1:0] c;
            logic       cen;
            c   = 2'($urandom_range(0, 3));
            cen = 1'($urandom_range(0, 1));
            RotCenter = cen;
            apply(c, $urandom_range(7, 12));
            model_apply(c);
            chk($sformatf("rnd%0d_count", i), Count, m_count);
            chk($sformatf("rnd%0d_right", i), Right, m_r);
            chk($sformatf("rnd%0d_left", i), Left, m_l);
            chk($sformatf("rnd%0d_center", i), Center, cen);
            chk($sformatf("rnd%0d_steps", i), step_cnt - base, m_steps);
        end

        chk("right_left_exclusive", both_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotary_dial_tracker.md
# rotary_dial_tracker

Front end of the combination lock. It synchronizes and debounces the raw quadrature rotary encoder (RotA, RotB) and the centre push-button. It decodes full detent steps and keeps a modulo-POSITIONS dial position. It drives Count, Right, Left and Center straight into combination_lock_fsm.

## Interface

Parameters:
- POSITIONS, default 20: number of dial positions; Count ranges 0..POSITIONS-1 (max 32).
- DEBOUNCE_CYCLES, default 4: consecutive stable clocks a synchronized input needs before its filtered value changes (≥1).

Ports:
- Clk  input  1  system clock.
- Rst  input  1  reset, synchronous, active-high.
- RotA  input  1  encoder channel A, asynchronous.
- RotB  input  1  encoder channel B, asynchronous.
- RotCenter  input  1  centre button, asynchronous, active-high.
- Count  output  5  current dial position.
- Right  output  1  level: the last completed detent was clockwise.
- Left  output  1  level: the last completed detent was counter-clockwise.
- Center  output  1  debounced centre button level.
- Step  output  1  one-cycle pulse on each completed detent.

## Operation

- **Synchronizers:** each of RotA, RotB and RotCenter passes through a 2-FF synchronizer. Reset value is 0.
- **Debounce filter:** one filter per synchronized signal.
  - Counts consecutive clocks on which the synchronized input differs from the filtered value.
  - The filtered value takes the new value on the DEBOUNCE_CYCLES-th such edge.
  - Any edge where the input equals the filtered value clears the counter.
  - Reset: filtered = 0, counter = 0.
- **Quadrature FSM** (states IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3), keyed on the filtered code AB:
  - IDLE: AB=10→CW1; AB=01→CCW1.
  - CW1: 11→CW2; 00→IDLE.
  - CW2: 01→CW3; 10→CW1.
  - CW3: 00→IDLE and emit CW step; 11→CW2.
  - CCW1: 11→CCW2; 00→IDLE.
  - CCW2: 10→CCW3; 01→CCW1.
  - CCW3: 00→IDLE and emit CCW step; 11→CCW2.
  - Any other code, including illegal two-bit jumps: hold state, no step.
  - Partial rotations that back out produce no step.
- **Count update** (registered):
  - On a CW step: Count = (Count == POSITIONS-1) ? 0 : Count+1.
  - On a CCW step: Count = (Count == 0) ? POSITIONS-1 : Count-1.
- **Direction and pulse:**
  - A CW step sets Right=1, Left=0; a CCW step sets Left=1, Right=0.
  - Right and Left are never both 1, and hold between steps.
  - Step=1 only in the cycle in which Count changes.
- **Center** equals the filtered RotCenter level. It is independent of rotation.

## Timing

- Reset values: Count=0, Right=0, Left=0, Center=0, Step=0, FSM=IDLE.
- Reset asserted mid-detent discards the partial detent, and discards any in-progress debounce counts.
- Latency, pin to filtered value: the synchronized value changes at edge 2 after the pin change is first sampled. The filtered value changes at edge 2+DEBOUNCE_CYCLES.
- Latency, to outputs: Count, Right, Left and Step update at edge 3+DEBOUNCE_CYCLES after the final 10/01→00 transition is stable at the pins. With default parameters this is 7 edges. Center changes at edge 2+DEBOUNCE_CYCLES.
- Glitches: a pin glitch shorter than DEBOUNCE_CYCLES clocks (after synchronization) has no effect.
- Throughput: at most one step per 4 filtered transitions. There is no step backlog; every step is applied the cycle it is decoded.
- Simultaneous A and B filtered change: treated as an illegal jump; state held.

## Structure

- **Package dial_pkg:**
  - dial_state_t enum of the seven FSM states.
  - localparam DIAL_POSITIONS = 20.
  - localparam COUNT_W = 5, shared with combination_lock_fsm.
- **Sub-module debounce_filter** (parameter DEBOUNCE_CYCLES; ports Clk, Rst, din, dout): contains the 2-FF synchronizer plus the stable counter. It is instantiated three times.
- **Top level:** holds the quadrature FSM and the Count/Right/Left/Step registers.

## Test plan

- **Reset:** hold Rst 3 cycles with pins toggling → Count=0, Right=Left=Step=0, Center=0. Releasing Rst with pins at 00 → no step.
- **Three CW detents:** apply 10,11,01,00 three times, each code stable 10 clocks → Count 0→1→2→3. Right=1, Left=0. Step is exactly 3 single-cycle pulses. The first Count change lands 7 edges after the final 00.
- **Wrap:** from Count=0, one CCW detent (01,11,10,00) → Count=19, Left=1. Then one CW detent → Count=0, Right=1.
- **Glitch and back-out:**
  - A 2-clock pulse on RotA → no FSM change.
  - The sequence 10,11,10,00 (backed out) → Count unchanged, no Step.
- **Illegal jump and reset mid-detent:**
  - From IDLE, apply 11 directly → state held, no step.
  - Drive 10,11 then assert Rst → FSM=IDLE and Count=0. Completing 01,00 afterwards produces no step.
- **Center:** hold RotCenter high for 3 clocks → Center stays 0. Hold it for 10 clocks → Center=1 at edge 6 after the first sample. Rotation is unaffected.
